// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ctrl_pkg
// Description : Shared constants and state encoding for the PWM duty
//               sequencer and the PWM top that instantiates it.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_ctrl_pkg;

    // Duty / PWM counter width used throughout the PWM subsystem
    localparam int DUTY_W = 10;

    // Defaults shared with the PWM top
    localparam int c_def_step_size        = 1;
    localparam int c_def_periods_per_step = 1;
    localparam int c_def_duty_max         = 1000;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } seq_state_t;

endpackage : pwm_ctrl_pkg
`default_nettype wire

// File: rtl/pwm_period_timer.sv
`default_nettype none
// ============================================================================
// Module      : pwm_period_timer
// Description : Free-running W-bit period counter kept in lockstep with the
//               PWM counter, plus a divider that turns every
//               PERIODS_PER_STEP-th period boundary into a ramp tick.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_period_timer
    import pwm_ctrl_pkg::*;
#(
    parameter int W                = DUTY_W,
    parameter int PERIODS_PER_STEP = c_def_periods_per_step
) (
    input  logic clk,
    input  logic rst,
    input  logic div_clr,
    output logic boundary,
    output logic period_start,
    output logic tick
);

    localparam int                 c_div_w    = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(PERIODS_PER_STEP - 1);
    localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
    localparam logic [W-1:0]       c_cnt_one  = W'(1);

    logic [W-1:0]       r_cnt;
    logic [c_div_w-1:0] r_div;

    // Period counter: wraps naturally from all-ones back to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // Boundary divider: restart on ramp entry so the first step waits a full interval
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (div_clr) begin
            r_div <= '0;
        end else if (boundary) begin
            r_div <= (r_div == c_div_last) ? '0 : r_div + c_div_one;
        end
    end

    assign boundary     = (r_cnt == '1);
    assign tick         = boundary && (r_div == c_div_last);
    // Masked during reset so every output reads 0 while rst is held
    assign period_start = (r_cnt == '0) && !rst;

endmodule : pwm_period_timer
`default_nettype wire

// File: rtl/pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_sequencer
// Description : Accepts duty targets over valid/ready, slews the applied PWM
//               duty toward the target one step per tick, updating only at
//               PWM period boundaries. Soft-stops on enable removal and
//               shuts down immediately on fault.
//               Optional macro PWM_DUTY_CLAMP_EN: clamps accepted targets
//               to DUTY_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_sequencer
    import pwm_ctrl_pkg::*;
#(
    parameter int W                = DUTY_W,
    parameter int PERIODS_PER_STEP = c_def_periods_per_step,
    parameter int DUTY_MAX         = c_def_duty_max
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] tgt_duty,
    input  logic         tgt_vld,
    output logic         tgt_rdy,
    input  logic [W-1:0] step_size,
    input  logic         fault,
    input  logic         fault_clr,
    output logic [W-1:0] duty,
    output logic         pwm_gate,
    output logic         period_start,
    output logic         at_target,
    output logic         busy
);

    localparam logic [W-1:0] c_step_min = W'(1);

    seq_state_t   r_state;
    seq_state_t   w_state_nxt;
    logic [W-1:0] r_duty;
    logic [W-1:0] r_target;
    logic [W-1:0] w_duty_nxt;
    logic [W-1:0] w_target_nxt;
    logic         w_div_clr;
    logic         w_boundary;
    logic         w_tick;
    logic         w_xfer;
    logic [W-1:0] w_tgt_in;
    logic [W-1:0] w_eff;
    logic [W-1:0] w_step;
    logic [W:0]   w_duty_x;
    logic [W:0]   w_eff_x;
    logic [W:0]   w_step_x;
    logic [W:0]   w_gap_x;
    logic [W:0]   w_move_x;
    logic [W:0]   w_ramped_x;
    logic         w_up;

    pwm_period_timer #(
        .W                (W),
        .PERIODS_PER_STEP (PERIODS_PER_STEP)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .div_clr      (w_div_clr),
        .boundary     (w_boundary),
        .period_start (period_start),
        .tick         (w_tick)
    );

    assign tgt_rdy = en && (r_state != FAULT);
    assign w_xfer  = tgt_vld && tgt_rdy;

`ifdef PWM_DUTY_CLAMP_EN
    localparam logic [W-1:0] c_duty_max = W'(DUTY_MAX);
    assign w_tgt_in = (tgt_duty > c_duty_max) ? c_duty_max : tgt_duty;
`else
    assign w_tgt_in = tgt_duty;
`endif

    // Disabled sequencer always heads for zero regardless of the stored target
    assign w_eff  = en ? r_target : '0;
    assign w_step = (step_size == '0) ? c_step_min : step_size;

    // One-bit-wider arithmetic so a step can never wrap past the target
    assign w_duty_x   = {1'b0, r_duty};
    assign w_eff_x    = {1'b0, w_eff};
    assign w_step_x   = {1'b0, w_step};
    assign w_up       = (w_eff_x > w_duty_x);
    assign w_gap_x    = w_up ? (w_eff_x - w_duty_x) : (w_duty_x - w_eff_x);
    assign w_move_x   = (w_step_x < w_gap_x) ? w_step_x : w_gap_x;
    assign w_ramped_x = w_up ? (w_duty_x + w_move_x) : (w_duty_x - w_move_x);

    // State, duty and target registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_duty   <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_duty   <= w_duty_nxt;
            r_target <= w_target_nxt;
        end
    end

    // Next-state and duty datapath; fault overrides everything else
    always_comb begin
        w_state_nxt  = r_state;
        w_duty_nxt   = r_duty;
        w_target_nxt = w_xfer ? w_tgt_in : r_target;
        w_div_clr    = 1'b0;

        if (fault) begin
            w_state_nxt  = FAULT;
            w_duty_nxt   = '0;
            w_target_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_duty_nxt = '0;
                    if (w_xfer && (w_tgt_in != '0)) begin
                        w_state_nxt = RAMP;
                        w_div_clr   = 1'b1;
                    end
                end
                RAMP: begin
                    // Step uses the target held before this edge; a target
                    // accepted now only counts from the next tick
                    if (w_boundary && w_tick) begin
                        w_duty_nxt = w_ramped_x[W-1:0];
                        if (w_ramped_x == w_eff_x) begin
                            w_state_nxt = en ? HOLD : IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (!en && (r_duty == '0)) begin
                        w_state_nxt = IDLE;
                    end else if (w_eff != r_duty) begin
                        w_state_nxt = RAMP;
                        w_div_clr   = 1'b1;
                    end
                end
                FAULT: begin
                    w_duty_nxt   = '0;
                    w_target_nxt = '0;
                    if (fault_clr) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_duty_nxt  = '0;
                end
            endcase
        end
    end

    assign duty      = r_duty;
    assign pwm_gate  = (r_state == RAMP) || (r_state == HOLD);
    assign busy      = (r_state == RAMP);
    assign at_target = (r_state == HOLD) && (r_duty == r_target);

endmodule : pwm_duty_sequencer
`default_nettype wire

// File: tb/tb_pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_sequencer
// Description : Scoreboard bench for pwm_duty_sequencer. Expected duty values
//               are queued as stimulus is applied and compared whenever the
//               applied duty changes. A second instance with
//               PERIODS_PER_STEP=3 checks the step spacing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_sequencer;

    localparam int W = 10;
`ifdef PWM_DUTY_CLAMP_EN
    localparam int c_big = 1000;
`else
    localparam int c_big = 1023;
`endif
    localparam int c_per = 1024;

    typedef struct {
        int v;
        bit al;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] tgt_duty;
    logic         tgt_vld;
    logic [W-1:0] step_size;
    logic         fault;
    logic         fault_clr;

    logic         tgt_rdy, pwm_gate, period_start, at_target, busy;
    logic [W-1:0] duty;
    logic         tgt_rdy3, pwm_gate3, period_start3, at_target3, busy3;
    logic [W-1:0] duty3;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp;
    int   n_bad;
    int   mon_prev;
    int   prev3;
    bit   prev_busy3;
    int   cnt3;
    bit   mon3;

    pwm_duty_sequencer #(.W(W), .PERIODS_PER_STEP(1), .DUTY_MAX(1000)) dut (
        .clk(clk), .rst(rst), .en(en), .tgt_duty(tgt_duty), .tgt_vld(tgt_vld),
        .tgt_rdy(tgt_rdy), .step_size(step_size), .fault(fault), .fault_clr(fault_clr),
        .duty(duty), .pwm_gate(pwm_gate), .period_start(period_start),
        .at_target(at_target), .busy(busy)
    );

    pwm_duty_sequencer #(.W(W), .PERIODS_PER_STEP(3), .DUTY_MAX(1000)) dut3 (
        .clk(clk), .rst(rst), .en(en), .tgt_duty(tgt_duty), .tgt_vld(tgt_vld),
        .tgt_rdy(tgt_rdy3), .step_size(step_size), .fault(fault), .fault_clr(fault_clr),
        .duty(duty3), .pwm_gate(pwm_gate3), .period_start(period_start3),
        .at_target(at_target3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push(input int v, input bit al);
        exp_t e;
        e.v  = v;
        e.al = al;
        q.push_back(e);
    endtask

    // Reference slew: queue every intermediate duty from 'from' to 'eff'
    task automatic push_ramp(input int from, input int eff, input int s);
        int d;
        int st;
        d  = from;
        st = (s == 0) ? 1 : s;
        while (d != eff) begin
            if (eff > d) d = ((eff - d) < st) ? eff : d + st;
            else         d = ((d - eff) < st) ? eff : d - st;
            push(d, 1'b1);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return at_target;
            1:       return !pwm_gate;
            2:       return duty == 10'd200;
            default: return at_target3;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string tag);
        int n;
        n = 0;
        while (!cond(sel) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, int'(cond(sel)), 1);
    endtask

    task automatic send(input int v);
        logic [31:0] vv;
        vv = v;
        @(negedge clk);
        chk("send_rdy", int'(tgt_rdy), 1);
        tgt_duty = vv[W-1:0];
        tgt_vld  = 1'b1;
        @(negedge clk);
        tgt_vld  = 1'b0;
    endtask

    // Duty scoreboard: every change must match the next queued value
    initial begin
        mon_prev = 0;
        forever begin
            @(negedge clk);
            if (int'(duty) != mon_prev) begin
                if (q.size() == 0) begin
                    chk("duty_unexpected", int'(duty), mon_prev);
                end else begin
                    mon_e = q.pop_front();
                    chk("duty_step", int'(duty), mon_e.v);
                    if (mon_e.al) chk("duty_align", int'(period_start), 1);
                end
                mon_prev = int'(duty);
            end
        end
    end

    // Spacing monitor for the 3-periods-per-step instance
    initial begin
        prev3      = 0;
        prev_busy3 = 1'b0;
        cnt3       = 0;
        forever begin
            @(negedge clk);
            if (period_start3) cnt3++;
            if (busy3 && !prev_busy3) cnt3 = 0;
            if (mon3 && (int'(duty3) != prev3)) begin
                chk("pps3_gap", cnt3, 3);
                cnt3 = 0;
            end
            prev3      = int'(duty3);
            prev_busy3 = busy3;
        end
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        mon3      = 1'b0;
        rst       = 1'b1;
        en        = 1'b0;
        tgt_duty  = '0;
        tgt_vld   = 1'b0;
        step_size = '0;
        fault     = 1'b0;
        fault_clr = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_duty", int'(duty), 0);
        chk("rst_gate", int'(pwm_gate), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_at_target", int'(at_target), 0);
        chk("rst_period_start", int'(period_start), 0);
        chk("rst_rdy_en0", int'(tgt_rdy), 0);
        en = 1'b1;
        #1;
        chk("rst_rdy_en1", int'(tgt_rdy), 1);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);

        // Ramp up to 350 in steps of 100, target accepted mid-period
        en        = 1'b1;
        step_size = 10'd100;
        mon3      = 1'b1;
        push_ramp(0, 350, 100);
        send(350);
        chk("ramp_busy", int'(busy), 1);
        chk("ramp_gate", int'(pwm_gate), 1);
        wait_for(0, 5 * c_per, "hold350");
        chk("hold_at_target", int'(at_target), 1);
        chk("hold_busy", int'(busy), 0);
        chk("hold_gate", int'(pwm_gate), 1);
        chk("hold_duty", int'(duty), 350);
        wait_for(3, 14 * c_per, "pps3_hold");
        chk("pps3_duty", int'(duty3), 350);
        mon3 = 1'b0;

        // Soft stop
        en = 1'b0;
        #1;
        chk("stop_rdy", int'(tgt_rdy), 0);
        push_ramp(350, 0, 100);
        wait_for(1, 6 * c_per, "stop1");
        chk("stop_busy", int'(busy), 0);
        chk("stop_duty", int'(duty), 0);

        // step_size 0 behaves as 1
        en        = 1'b1;
        step_size = 10'd0;
        push_ramp(0, 3, 0);
        send(3);
        wait_for(0, 5 * c_per, "step0");

        // Large step toward full scale without overflow
        step_size = 10'd1000;
        push_ramp(3, c_big, 1000);
        send(1023);
        wait_for(0, 4 * c_per, "big");
        chk("big_duty", int'(duty), c_big);

        en = 1'b0;
        push_ramp(c_big, 0, 1000);
        wait_for(1, 4 * c_per, "stop2");

        // Fault mid-ramp at duty 200
        en        = 1'b1;
        step_size = 10'd100;
        push_ramp(0, 200, 100);
        send(500);
        wait_for(2, 4 * c_per, "to200");
        repeat (5) @(negedge clk);
        push(0, 1'b0);
        fault = 1'b1;
        @(negedge clk);
        chk("fault_duty", int'(duty), 0);
        chk("fault_gate", int'(pwm_gate), 0);
        chk("fault_rdy", int'(tgt_rdy), 0);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        @(negedge clk);
        chk("fault_clr_ignored", int'(tgt_rdy), 0);
        fault = 1'b0;
        @(negedge clk);
        chk("fault_stays", int'(tgt_rdy), 0);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("fault_exit_rdy", int'(tgt_rdy), 1);
        chk("fault_exit_gate", int'(pwm_gate), 0);
        chk("fault_exit_busy", int'(busy), 0);

        // Retarget from HOLD, then asynchronous reset mid-ramp
        push_ramp(0, 100, 100);
        send(100);
        wait_for(0, 4 * c_per, "hold100");
        push(200, 1'b1);
        send(300);
        wait_for(2, 4 * c_per, "re200");
        repeat (10) @(negedge clk);
        push(0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_duty", int'(duty), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_gate", int'(pwm_gate), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pwm_duty_sequencer
`default_nettype wire

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
Sequences the duty input of the team's 10-bit free-running PWM generator.
- Accepts target duty values over a valid/ready handshake.
- Slews the applied duty toward the target, one step per N PWM periods.
- Changes duty only at PWM period boundaries. Handles soft-stop on disable and immediate shutdown on fault.
- Sits between the control logic and the PWM instance; also provides a gate for PWM_sig.

Parameters:
W, 10, duty/counter width; must match the PWM counter width.
PERIODS_PER_STEP, 1, PWM periods between successive ramp steps (>=1).
DUTY_MAX, 1000, clamp ceiling for targets (used only with the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset; top level drives the PWM rst_n from ~rst
en  in  1  run enable; deassertion causes a ramp down to 0
tgt_duty  in  W  requested duty
tgt_vld  in  1  tgt_duty valid
tgt_rdy  out  1  = en && state!=FAULT
step_size  in  W  duty increment per ramp step; 0 is treated as 1
fault  in  1  shutdown request, level-sensitive
fault_clr  in  1  one-cycle pulse that leaves FAULT
duty  out  W  applied duty to the PWM
pwm_gate  out  1  0 in IDLE/FAULT; top level ANDs it with PWM_sig (duty 0 still produces a 1-cycle PWM pulse)
period_start  out  1  one-cycle pulse on the cycle the period counter is 0
at_target  out  1  duty==target register && state==HOLD
busy  out  1  state==RAMP

Behaviour:
Reset (async, rst=1):
- duty=0, target=0, state=IDLE, period counter=0, divider=0.
- All outputs 0 except tgt_rdy (follows its equation).

Period counter:
- W-bit, +1 every clk, wraps at 2^W-1 -> 0. Stays in lockstep with the PWM counter because both leave reset together.
- Boundary = counter==2^W-1. A duty register update occurs only on the clock edge at a boundary, so the new duty is applied starting at count 0.

Step tick:
- Divider counts boundaries 0..PERIODS_PER_STEP-1.
- Tick = boundary && divider==PERIODS_PER_STEP-1.
- Divider clears on entry to RAMP.

Handshake:
- Transfer on tgt_vld && tgt_rdy; the target register loads on that edge.
- A target accepted on a tick edge does not affect that tick's step; it is used from the next tick onward.
- Effective target = en ? target : 0.

States:
- IDLE: duty=0, pwm_gate=0.
  - en && accepted target > 0 -> RAMP.
- RAMP: on each tick, duty moves toward the effective target by min(max(step_size,1), |eff - duty|).
  - Arithmetic in W+1 bits; no overflow or underflow past the target.
  - If the updated duty == eff: go to HOLD when en=1, go to IDLE when en=0.
- HOLD: duty constant.
  - A new target != duty, or en falling -> RAMP.
  - en=0 with duty already 0 -> IDLE.
- FAULT: entered from any state when fault=1.
  - duty=0 on the next edge, without waiting for a boundary. pwm_gate=0. Target register cleared.
  - Exit to IDLE only when fault_clr=1 && fault=0.
  - fault_clr while fault=1 is ignored.

Priority: reset > fault > en deassert > new target > tick.

Rules:
- Retargeting during RAMP is allowed; the ramp direction can reverse at the next tick.
- pwm_gate=1 in RAMP and HOLD.

Optional Feature:
PWM_DUTY_CLAMP_EN:
- Defined: an accepted tgt_duty above DUTY_MAX is stored as DUTY_MAX, so duty never exceeds DUTY_MAX.
- Undefined: tgt_duty is stored unmodified and the full 0..2^W-1 range is reachable; DUTY_MAX is unused.

Decomposition:
- Package pwm_ctrl_pkg holds: the DUTY_W=10 constant, the state enum typedef (IDLE, RAMP, HOLD, FAULT), and default step/period constants shared with the PWM top.
- One natural sub-module, pwm_period_timer: the period counter plus the PERIODS_PER_STEP divider. Outputs are boundary, period_start and tick.
- The FSM and duty datapath stay in pwm_duty_sequencer.

Test Plan:
Ramp up:
- Reset, en=1, step_size=100, send target 350 -> duty 0 -> 100 -> 200 -> 300 -> 350 at successive boundaries (every 1024 clks); then HOLD, at_target=1, busy=0.

Boundary alignment:
- Target accepted mid-period -> duty is unchanged until the edge where the counter goes 1023 -> 0. Check that duty never changes when the counter != 1023.

Soft stop:
- From HOLD at 350, drop en (step 100) -> duty 250, 150, 50, 0 at boundaries -> IDLE, pwm_gate=0.
- tgt_rdy=0 while en=0.

Fault:
- Assert fault mid-ramp at duty 200 -> duty=0 and pwm_gate=0 on the next clk.
- fault_clr while fault=1 keeps FAULT.
- Deassert fault, then pulse fault_clr -> IDLE.

Corner cases:
- step_size=0 behaves as step 1.
- target 1023 with step 1000 -> 1000 -> 1023, no overflow.
- PERIODS_PER_STEP=3 -> a step every 3rd boundary.
- Async rst mid-RAMP -> duty=0 immediately.

Clamp:
- With PWM_DUTY_CLAMP_EN defined, target 1023 -> final duty 1000.
- Without it, target 1023 -> final duty 1023.
